// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register addressing, hazard causes, issue-slot states.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned NREG_DEFAULT = 32;

    // Reason the decoded instruction cannot issue; first matching cause wins.
    typedef enum logic [1:0] {
        HazNone,
        HazRawRs1,
        HazRawRs2,
        HazWaw
    } haz_cause_e;

    // Occupancy of the single issue slot.
    typedef enum logic {
        SlotEmpty,
        SlotFull
    } slot_state_e;

endpackage

// File: rtl/sb_hazard_check.sv
// Combinational hazard evaluation of one decoded instruction against the busy bits.
// Register x0 never produces a hazard.
module sb_hazard_check
    import cpu_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEFAULT
) (
    input  logic [NREG-1:0]       i_busy,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic                  i_rs1_en,
    input  logic                  i_rs2_en,
    input  logic                  i_rd_we,
    output haz_cause_e            o_cause,
    output logic                  o_hazard
);

    logic w_raw1;
    logic w_raw2;
    logic w_waw;

    // Classify the hazard; reads come before the write check.
    always_comb begin
        w_raw1   = i_rs1_en && (i_rs1 != '0) && i_busy[i_rs1];
        w_raw2   = i_rs2_en && (i_rs2 != '0) && i_busy[i_rs2];
        w_waw    = i_rd_we  && (i_rd  != '0) && i_busy[i_rd];
        o_cause  = HazNone;
        if (w_raw1) begin
            o_cause = HazRawRs1;
        end else if (w_raw2) begin
            o_cause = HazRawRs2;
        end else if (w_waw) begin
            o_cause = HazWaw;
        end
        o_hazard = (o_cause != HazNone);
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register busy-bit scoreboard with a one-entry issue slot and a saturating stall counter.
// Optional feature: HAZARD_WB_BYPASS_EN lets a same-cycle writeback unblock the
// dependent instruction in that cycle.
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned NREG  = NREG_DEFAULT,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic                  dec_rs1_en,
    input  logic                  dec_rs2_en,
    input  logic                  dec_rd_we,
    output logic                  iss_valid,
    input  logic                  iss_ready,
    output logic [REG_ADDR_W-1:0] iss_rd,
    output logic                  iss_rd_we,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  flush,
    output logic [NREG-1:0]       busy_mask,
    output logic [CNT_W-1:0]      stall_cnt
);

    // Every register except x0 may hold a busy bit.
    localparam logic [NREG-1:0] BusyKeep = {{(NREG-1){1'b1}}, 1'b0};

    logic [NREG-1:0]       r_busy;
    slot_state_e           r_state;
    logic [REG_ADDR_W-1:0] r_iss_rd;
    logic                  r_iss_rd_we;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic [NREG-1:0]       w_wb_clr;
    logic [NREG-1:0]       w_set;
    logic [NREG-1:0]       w_busy_eff;
    logic                  w_rd_we;
    logic                  w_hazard;
    logic                  w_accept;
    haz_cause_e            w_cause;

    // Writeback clear and issue set masks; x0 is excluded from both.
    always_comb begin
        w_wb_clr = '0;
        w_set    = '0;
        w_rd_we  = dec_rd_we && (dec_rd != '0);
        if (wb_valid && (wb_rd != '0)) begin
            w_wb_clr[wb_rd] = 1'b1;
        end
        if (w_accept && w_rd_we) begin
            w_set[dec_rd] = 1'b1;
        end
    end

    // Busy view seen by the hazard check.
    always_comb begin
`ifdef HAZARD_WB_BYPASS_EN
        w_busy_eff = r_busy & ~w_wb_clr;
`else
        w_busy_eff = r_busy;
`endif
    end

    sb_hazard_check #(
        .NREG(NREG)
    ) u_hazard_check (
        .i_busy   (w_busy_eff),
        .i_rs1    (dec_rs1),
        .i_rs2    (dec_rs2),
        .i_rd     (dec_rd),
        .i_rs1_en (dec_rs1_en),
        .i_rs2_en (dec_rs2_en),
        .i_rd_we  (dec_rd_we),
        .o_cause  (w_cause),
        .o_hazard (w_hazard)
    );

    // Handshake: slot must be free or draining this cycle.
    always_comb begin
        dec_ready = !w_hazard && !flush && !rst && (!iss_valid || iss_ready);
        w_accept  = dec_valid && dec_ready;
    end

    // Scoreboard update; set wins over a same-register clear, flush clears all.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_wb_clr) | w_set) & BusyKeep;
        end
    end

    // Issue slot FSM with registered issue fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SlotEmpty;
            r_iss_rd    <= '0;
            r_iss_rd_we <= 1'b0;
        end else if (flush) begin
            r_state     <= SlotEmpty;
            r_iss_rd_we <= 1'b0;
        end else begin
            case (r_state)
                SlotEmpty: begin
                    if (w_accept) begin
                        r_state     <= SlotFull;
                        r_iss_rd    <= dec_rd;
                        r_iss_rd_we <= w_rd_we;
                    end
                end
                SlotFull: begin
                    if (w_accept) begin
                        r_iss_rd    <= dec_rd;
                        r_iss_rd_we <= w_rd_we;
                    end else if (iss_ready) begin
                        r_state <= SlotEmpty;
                    end
                end
                default: r_state <= SlotEmpty;
            endcase
        end
    end

    // Saturating count of cycles where a valid decode was held back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (dec_valid && !dec_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign iss_valid = (r_state == SlotFull);
    assign iss_rd    = r_iss_rd;
    assign iss_rd_we = r_iss_rd_we;
    assign busy_mask = r_busy;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_rs1_en, dec_rs2_en, dec_rd_we;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rd;
    logic        iss_rd_we;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy_mask;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;

    hazard_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_rs1    (dec_rs1),
        .dec_rs2    (dec_rs2),
        .dec_rd     (dec_rd),
        .dec_rs1_en (dec_rs1_en),
        .dec_rs2_en (dec_rs2_en),
        .dec_rd_we  (dec_rd_we),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_rd     (iss_rd),
        .iss_rd_we  (iss_rd_we),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .flush      (flush),
        .busy_mask  (busy_mask),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dec(input logic v, input logic [4:0] rs1, input logic e1,
                       input logic [4:0] rs2, input logic e2,
                       input logic [4:0] rd, input logic we);
        dec_valid  = v;
        dec_rs1    = rs1;
        dec_rs1_en = e1;
        dec_rs2    = rs2;
        dec_rs2_en = e2;
        dec_rd     = rd;
        dec_rd_we  = we;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0; iss_ready = 1'b1;
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        #1;
        chk("rst_dec_ready", dec_ready, 1'b0);
        tick(); tick();
        chk("rst_busy", busy_mask, 32'h0);
        chk("rst_iss_valid", iss_valid, 1'b0);
        chk("rst_iss_rd", iss_rd, 5'd0);
        chk("rst_iss_rd_we", iss_rd_we, 1'b0);
        chk("rst_stall", stall_cnt, 16'd0);

        // Accept rd=5 into an empty slot.
        rst = 1'b0;
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        #1;
        chk("acc5_ready", dec_ready, 1'b1);
        tick();
        chk("acc5_iss_valid", iss_valid, 1'b1);
        chk("acc5_iss_rd", iss_rd, 5'd5);
        chk("acc5_iss_rd_we", iss_rd_we, 1'b1);
        chk("acc5_busy", busy_mask, 32'h0000_0020);

        // RAW on x5 stalls until writeback.
        dec(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
        #1;
        chk("raw_ready", dec_ready, 1'b0);
        tick(); tick();
        exp_stall += 2;
        chk("raw_stall2", stall_cnt, 16'(exp_stall));
        wb_valid = 1'b1; wb_rd = 5'd5;
        #1;
`ifdef HAZARD_WB_BYPASS_EN
        chk("wb_bypass_ready", dec_ready, 1'b1);
        tick();
        wb_valid = 1'b0;
`else
        chk("wb_nobypass_ready", dec_ready, 1'b0);
        tick();
        exp_stall += 1;
        wb_valid = 1'b0;
        chk("wb_busy_clear", busy_mask, 32'h0);
        #1;
        chk("after_wb_ready", dec_ready, 1'b1);
        tick();
`endif
        chk("dep_iss_rd", iss_rd, 5'd6);
        chk("dep_busy", busy_mask, 32'h0000_0040);
        chk("dep_stall", stall_cnt, 16'(exp_stall));

        // Write to x0 issues but never marks busy.
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        #1;
        chk("x0_ready", dec_ready, 1'b1);
        tick();
        chk("x0_iss_valid", iss_valid, 1'b1);
        chk("x0_iss_rd_we", iss_rd_we, 1'b0);
        chk("x0_busy", busy_mask, 32'h0000_0040);

        // Back-pressure: slot holds for three cycles.
        iss_ready = 1'b0;
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        #1;
        chk("bp_ready", dec_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_iss_valid", iss_valid, 1'b1);
            chk("bp_iss_rd", iss_rd, 5'd0);
            chk("bp_iss_rd_we", iss_rd_we, 1'b0);
        end
        exp_stall += 3;
        chk("bp_stall", stall_cnt, 16'(exp_stall));
        iss_ready = 1'b1;
        dec_valid = 1'b0;
        tick();
        chk("drain_iss_valid", iss_valid, 1'b0);

        // Accept rd=8 while x6 retires in the same cycle.
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
        wb_valid = 1'b1; wb_rd = 5'd6;
        tick();
        wb_valid = 1'b0;
        chk("wbacc_busy", busy_mask, 32'h0000_0100);
        chk("wbacc_iss_rd", iss_rd, 5'd8);

        // Flush, then fill x4..x7 back to back.
        dec_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush1_busy", busy_mask, 32'h0);
        for (int r = 4; r < 8; r++) begin
            dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1);
            tick();
        end
        chk("fill_busy", busy_mask, 32'h0000_00F0);
        chk("fill_iss_rd", iss_rd, 5'd7);
        chk("fill_iss_valid", iss_valid, 1'b1);

        // Flush beats writeback and a valid decode.
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        wb_valid = 1'b1; wb_rd = 5'd4; flush = 1'b1;
        #1;
        chk("flush_ready", dec_ready, 1'b0);
        tick();
        exp_stall += 1;
        flush = 1'b0; wb_valid = 1'b0; dec_valid = 1'b0;
        chk("flush_busy", busy_mask, 32'h0);
        chk("flush_iss_valid", iss_valid, 1'b0);
        chk("flush_stall", stall_cnt, 16'(exp_stall));

        // Saturation of the stall counter.
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        tick();
        chk("sat_busy", busy_mask, 32'h0000_0008);
        dec(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        for (int i = exp_stall; i < 16'hFFFE; i++) tick();
        chk("sat_fffe", stall_cnt, 16'hFFFE);
        dec(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        #1;
        chk("rs2_ready", dec_ready, 1'b0);
        tick(); tick(); tick();
        chk("sat_ffff", stall_cnt, 16'hFFFF);
        rst = 1'b1;
        tick();
        chk("sat_rst_stall", stall_cnt, 16'h0);
        chk("sat_rst_busy", busy_mask, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
